w5300_bus_timer: RTL
====================

W5300_BUS_TIMER -- requirements
Module: w5300_bus_timer

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: clocks of wizcsl low before the strobe asserts (range 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 4: clocks of strobe low before dtackl asserts (range 1..15).
REQ-003 SHALL have parameter RECOVER_CYC, default 2: clocks with all strobes high after a cycle ends (range 1..15).
REQ-004 SHALL have parameter RST_LOW_CYC, default 100: clocks that wizrstl is held low.
REQ-005 SHALL have parameter RST_WAIT_CYC, default 400000: clocks after wizrstl rises before busy clears; counter width 20 bits.
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 sel  in  1  asynchronous; high while the decoded W5300 data address is active.
REQ-009 dsl  in  1  asynchronous; QL data strobe, active low.
REQ-010 rdwl  in  1  QL read/write; 1 = read; sampled on entry to SETUP.
REQ-011 reset_req  in  1  synchronous one-clock pulse requesting a W5300 hardware reset.
REQ-012 wizcsl, wizrdl, wizwrl  out  1 each  W5300 chip select, read strobe and write strobe; active low; registered.
REQ-013 dbenl  out  1  data buffer enable; active low; registered.
REQ-014 dtackl  out  1  QL data acknowledge; active low; registered.
REQ-015 wizrstl  out  1  W5300 reset; active low; registered.
REQ-016 busy  out  1  high while the reset sequence is in progress.

Function
REQ-017 SHALL pass sel and dsl through two-flop synchronisers (sel_s, dsl_s) before any use.
REQ-018 Bus FSM states SHALL be IDLE, SETUP, STROBE, ACK and RECOVER, with one shared 4-bit counter.
REQ-019 IDLE: all outputs inactive; go to SETUP when sel_s=1 and dsl_s=0, latching rdwl as dir.
REQ-020 SETUP: wizcsl=0, dbenl=0, strobes high; go to STROBE after SETUP_CYC clocks.
REQ-021 STROBE: wizcsl=0, dbenl=0; wizrdl=0 if dir=read, else wizwrl=0; go to ACK after STROBE_CYC clocks.
REQ-022 ACK, read: wizcsl=0, wizrdl=0, dbenl=0, dtackl=0; hold until dsl_s=1, then go to RECOVER.
REQ-023 ACK, write: wizwrl=1 (rising edge on entry to ACK), wizcsl=0, dbenl=0, dtackl=0; hold until dsl_s=1, then go to RECOVER.
REQ-024 RECOVER: all outputs inactive; go to IDLE after RECOVER_CYC clocks; a new access SHALL NOT start before IDLE.
REQ-025 Abort: if dsl_s=1 or sel_s=0 in SETUP or STROBE, go to RECOVER next clock with dtackl kept high.
REQ-026 Latency: wizcsl SHALL fall on the 3rd rising clk edge after dsl is sampled low, the strobe SETUP_CYC edges later, and dtackl STROBE_CYC edges after the strobe.
REQ-027 Reset FSM states SHALL be RUN, RST_LOW and RST_WAIT.
REQ-028 RST_LOW: wizrstl=0, busy=1; go to RST_WAIT after RST_LOW_CYC clocks.
REQ-029 RST_WAIT: wizrstl=1, busy=1; go to RUN after RST_WAIT_CYC clocks.
REQ-030 RUN: busy=0.
REQ-031 A reset_req in any reset state SHALL enter RST_LOW with the counter cleared (restart).
REQ-032 While busy=1, bus cycles SHALL run the full FSM timing with wizcsl, wizrdl and wizwrl held high (dtackl still asserts, so the QL bus does not hang).
REQ-033 A reset_req during a bus cycle SHALL NOT disturb the bus FSM; strobes are gated from the next clock per REQ-032.

Reset
REQ-034 On rst=1: bus FSM goes to IDLE and all bus counters clear.
REQ-035 On rst=1: wizcsl=wizrdl=wizwrl=dbenl=dtackl=1 and both synchronisers are loaded to the inactive values (sel_s=0, dsl_s=1).
REQ-036 On rst=1: reset FSM goes to RST_LOW with wizrstl=0 and busy=1, giving a power-on W5300 reset.

Verification
REQ-037 rst for 1 clock, then idle -> wizrstl=0 for 100 clocks, busy=1 until 400100 clocks after rst released, then busy=0.
REQ-038 After busy=0, read with sel=1, dsl low at edge 0 -> wizcsl falls at edge 3, wizrdl at 4, dtackl at 8; dsl high -> all high 3 clocks later, IDLE after 2 more.
REQ-039 Write with the same stimulus -> wizwrl low edges 4-7, rising at edge 8 with dtackl low, wizcsl low until dsl_s=1.
REQ-040 dsl released at edge 5 (in STROBE) -> dtackl never asserts, strobes high by edge 8, RECOVER lasts 2 clocks.
REQ-041 reset_req at RST_WAIT count 1000 -> wizrstl=0 again for a full 100 clocks, busy stays high throughout.
REQ-042 Read access during busy=1 -> dtackl asserts at edge 8 with wizcsl and wizrdl held high throughout.

Source files
------------

// File: rtl/w5300_bus_timer_if.sv
// QL-side request signals and W5300-side strobes handled by the bus timer.
interface w5300_bus_timer_if;
  logic sel;
  logic dsl;
  logic rdwl;
  logic wizcsl;
  logic wizrdl;
  logic wizwrl;
  logic dbenl;
  logic dtackl;

  modport master (
    output sel, dsl, rdwl,
    input  wizcsl, wizrdl, wizwrl, dbenl, dtackl
  );

  modport slave (
    input  sel, dsl, rdwl,
    output wizcsl, wizrdl, wizwrl, dbenl, dtackl
  );
endinterface

// File: rtl/w5300_bus_timer.sv
// Stretches asynchronous QL data-strobe cycles into W5300 chip-select/strobe timing
// and sequences the W5300 hardware reset, gating the chip strobes while it runs.
module w5300_bus_timer #(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 4,
  parameter int RECOVER_CYC  = 2,
  parameter int RST_LOW_CYC  = 100,
  parameter int RST_WAIT_CYC = 400000
) (
  input  logic             clk,
  input  logic             rst,
  w5300_bus_timer_if.slave bus,
  input  logic             reset_req,
  output logic             wizrstl,
  output logic             busy
);

  localparam logic [3:0]  SETUP_LAST    = 4'(SETUP_CYC - 1);
  localparam logic [3:0]  STROBE_LAST   = 4'(STROBE_CYC - 1);
  localparam logic [3:0]  RECOVER_LAST  = 4'(RECOVER_CYC - 1);
  localparam logic [19:0] RST_LOW_LAST  = 20'(RST_LOW_CYC - 1);
  localparam logic [19:0] RST_WAIT_LAST = 20'(RST_WAIT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, ACK, RECOVER} bus_state_t;
  typedef enum logic [1:0] {RUN, RST_LOW, RST_WAIT} rst_state_t;

  logic        sel_m, sel_s;
  logic        dsl_m, dsl_s;
  logic        abort;
  logic        dir;
  bus_state_t  bus_state;
  logic [3:0]  bus_cnt;
  rst_state_t  rst_state;
  logic [19:0] rst_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_m <= 1'b0;
      sel_s <= 1'b0;
      dsl_m <= 1'b1;
      dsl_s <= 1'b1;
    end else begin
      sel_m <= bus.sel;
      sel_s <= sel_m;
      dsl_m <= bus.dsl;
      dsl_s <= dsl_m;
    end
  end

  assign abort = dsl_s || !sel_s;

  // Outputs decode the state held before each edge, so every output lags its state by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_state  <= IDLE;
      bus_cnt    <= '0;
      dir        <= 1'b1;
      bus.wizcsl <= 1'b1;
      bus.wizrdl <= 1'b1;
      bus.wizwrl <= 1'b1;
      bus.dbenl  <= 1'b1;
      bus.dtackl <= 1'b1;
    end else begin
      bus.wizcsl <= 1'b1;
      bus.wizrdl <= 1'b1;
      bus.wizwrl <= 1'b1;
      bus.dbenl  <= 1'b1;
      bus.dtackl <= 1'b1;
      case (bus_state)
        IDLE: begin
          bus_cnt <= '0;
          if (sel_s && !dsl_s) begin
            dir       <= bus.rdwl;
            bus_state <= SETUP;
          end
        end
        SETUP: begin
          bus.wizcsl <= busy;
          bus.dbenl  <= 1'b0;
          if (abort) begin
            bus_state <= RECOVER;
            bus_cnt   <= '0;
          end else if (bus_cnt == SETUP_LAST) begin
            bus_state <= STROBE;
            bus_cnt   <= '0;
          end else begin
            bus_cnt <= bus_cnt + 4'd1;
          end
        end
        STROBE: begin
          bus.wizcsl <= busy;
          bus.dbenl  <= 1'b0;
          if (dir) bus.wizrdl <= busy;
          else     bus.wizwrl <= busy;
          if (abort) begin
            bus_state <= RECOVER;
            bus_cnt   <= '0;
          end else if (bus_cnt == STROBE_LAST) begin
            bus_state <= ACK;
            bus_cnt   <= '0;
          end else begin
            bus_cnt <= bus_cnt + 4'd1;
          end
        end
        ACK: begin
          // A write releases wizwrl here so the W5300 latches data on that rising edge.
          bus.wizcsl <= busy;
          bus.dbenl  <= 1'b0;
          bus.dtackl <= 1'b0;
          if (dir) bus.wizrdl <= busy;
          if (dsl_s) begin
            bus_state <= RECOVER;
            bus_cnt   <= '0;
          end
        end
        RECOVER: begin
          if (bus_cnt == RECOVER_LAST) begin
            bus_state <= IDLE;
            bus_cnt   <= '0;
          end else begin
            bus_cnt <= bus_cnt + 4'd1;
          end
        end
        default: begin
          bus_state <= IDLE;
          bus_cnt   <= '0;
        end
      endcase
    end
  end

  // A reset request restarts the low phase from any state without touching the bus FSM.
  always_ff @(posedge clk) begin
    if (rst || reset_req) begin
      rst_state <= RST_LOW;
      rst_cnt   <= '0;
      wizrstl   <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (rst_state)
        RST_LOW: begin
          if (rst_cnt == RST_LOW_LAST) begin
            rst_state <= RST_WAIT;
            rst_cnt   <= '0;
            wizrstl   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 20'd1;
          end
        end
        RST_WAIT: begin
          if (rst_cnt == RST_WAIT_LAST) begin
            rst_state <= RUN;
            rst_cnt   <= '0;
            busy      <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 20'd1;
          end
        end
        RUN: begin
          rst_cnt <= '0;
          wizrstl <= 1'b1;
          busy    <= 1'b0;
        end
        default: begin
          rst_state <= RST_LOW;
          rst_cnt   <= '0;
          wizrstl   <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule
